// File: rtl/ucdp_hold_bank_pkg.sv
// Shared types for the hold bank: per-channel lock state.
package ucdp_hold_bank_pkg;

    typedef enum logic [0:0] {
        Open   = 1'b0,
        Locked = 1'b1
    } chstate_t;

endpackage

// File: rtl/ucdp_hold_chan.sv
// One hold-bank channel: lock FSM, active register, optional staging register.
module ucdp_hold_chan
    import ucdp_hold_bank_pkg::*;
#(
    parameter int unsigned          width_p  = 1,
    parameter logic [width_p-1:0]   rstval_p = '0,
    parameter bit                   transp_p = 1'b1,
    parameter bit                   shadow_p = 1'b0
) (
    input  logic                main_clk_i,
    input  logic                main_rst_i,
    input  logic                dft_mode_test_mode_i,
    input  logic                dft_mode_scan_mode_i,
    input  logic                dft_mode_scan_shift_i,
    input  logic                dft_mode_mbist_mode_i,
    input  logic                ld_i,
    input  logic [width_p-1:0]  d_i,
    input  logic                lock_i,
    input  logic                unlock_i,
    input  logic                upd_i,
    output logic [width_p-1:0]  q_o,
    output logic                locked_o,
    output logic                pend_o,
    output logic                chg_o
);

    chstate_t           state_q, state_d;
    logic               open;
    logic               accept;
    logic [width_p-1:0] act_q, act_d;
    logic [width_p-1:0] stg_q, stg_d;
    logic               pend_q, pend_d;
    logic               chg_q;

    // Only scan mode affects behaviour; the other test controls are intentionally ignored.
    logic unused_dft;
    assign unused_dft = dft_mode_test_mode_i ^ dft_mode_scan_shift_i ^ dft_mode_mbist_mode_i;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= Open;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock takes priority when both requests arrive together.
    always_comb begin
        state_d = state_q;
        if (lock_i) begin
            state_d = Locked;
        end else if (unlock_i) begin
            state_d = Open;
        end
    end

    always_comb begin
        open     = (state_q == Open);
        locked_o = (state_q == Locked);
    end

    assign accept = ld_i && open && !main_rst_i;

    always_comb begin
        act_d  = act_q;
        stg_d  = stg_q;
        pend_d = pend_q;
        if (shadow_p) begin
            if (accept) begin
                stg_d  = d_i;
                pend_d = 1'b1;
            end
            if (upd_i) begin
                if (accept) begin
                    act_d  = d_i;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    act_d  = stg_q;
                    pend_d = 1'b0;
                end
            end
        end else if (accept) begin
            act_d = d_i;
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            act_q  <= rstval_p;
            stg_q  <= rstval_p;
            pend_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            act_q  <= act_d;
            stg_q  <= stg_d;
            pend_q <= pend_d;
            chg_q  <= (act_d != act_q);
        end
    end

    always_comb begin
        q_o = act_q;
        if (!shadow_p && transp_p && !dft_mode_scan_mode_i && accept) begin
            q_o = d_i;
        end
    end

    assign pend_o = pend_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/ucdp_hold_bank.sv
// Bank of independent lockable hold registers; one ucdp_hold_chan per channel.
module ucdp_hold_bank
    import ucdp_hold_bank_pkg::*;
#(
    parameter int unsigned          width_p  = 1,
    parameter int unsigned          chnum_p  = 1,
    parameter logic [width_p-1:0]   rstval_p = '0,
    parameter bit                   transp_p = 1'b1,
    parameter bit                   shadow_p = 1'b0
) (
    input  logic                        main_clk_i,
    input  logic                        main_rst_i,
    input  logic                        dft_mode_test_mode_i,
    input  logic                        dft_mode_scan_mode_i,
    input  logic                        dft_mode_scan_shift_i,
    input  logic                        dft_mode_mbist_mode_i,
    input  logic [chnum_p-1:0]          ld_i,
    input  logic [chnum_p*width_p-1:0]  d_i,
    input  logic [chnum_p-1:0]          lock_i,
    input  logic [chnum_p-1:0]          unlock_i,
    input  logic                        upd_i,
    output logic [chnum_p*width_p-1:0]  q_o,
    output logic [chnum_p-1:0]          locked_o,
    output logic [chnum_p-1:0]          pend_o,
    output logic [chnum_p-1:0]          chg_o
);

    for (genvar n = 0; n < chnum_p; n++) begin : g_chan
        ucdp_hold_chan #(
            .width_p  (width_p),
            .rstval_p (rstval_p),
            .transp_p (transp_p),
            .shadow_p (shadow_p)
        ) u_chan (
            .main_clk_i            (main_clk_i),
            .main_rst_i            (main_rst_i),
            .dft_mode_test_mode_i  (dft_mode_test_mode_i),
            .dft_mode_scan_mode_i  (dft_mode_scan_mode_i),
            .dft_mode_scan_shift_i (dft_mode_scan_shift_i),
            .dft_mode_mbist_mode_i (dft_mode_mbist_mode_i),
            .ld_i                  (ld_i[n]),
            .d_i                   (d_i[n*width_p +: width_p]),
            .lock_i                (lock_i[n]),
            .unlock_i              (unlock_i[n]),
            .upd_i                 (upd_i),
            .q_o                   (q_o[n*width_p +: width_p]),
            .locked_o              (locked_o[n]),
            .pend_o                (pend_o[n]),
            .chg_o                 (chg_o[n])
        );
    end

endmodule

// File: doc/ucdp_hold_bank.md
UCDP_HOLD_BANK -- requirements
Module: ucdp_hold_bank

Interface
REQ-001 SHALL have parameter width_p, default 1: data bits per channel.
REQ-002 SHALL have parameter chnum_p, default 1: number of independent channels (1..32).
REQ-003 SHALL have parameter rstval_p [width_p-1:0], default all-zero: reset value of every channel.
REQ-004 SHALL have parameter transp_p, default 1: 1 = accepted load visible on q_o in the same cycle.
REQ-005 SHALL have parameter shadow_p, default 0: 1 = loads are staged and committed by upd_i.
REQ-006 SHALL have one clock and one reset: main_clk_i and main_rst_i; reset is synchronous and active-high.
REQ-007 SHALL have main_clk_i  input  1  clock, all state on the rising edge.
REQ-008 SHALL have main_rst_i  input  1  synchronous reset, active-high.
REQ-009 SHALL have dft_mode_test_mode_i, dft_mode_scan_mode_i, dft_mode_scan_shift_i, dft_mode_mbist_mode_i  input  1 each  test control.
REQ-010 SHALL have ld_i  input  chnum_p  per-channel load request.
REQ-011 SHALL have d_i  input  chnum_p*width_p  packed data; channel n occupies bits [n*width_p +: width_p].
REQ-012 SHALL have lock_i / unlock_i  input  chnum_p each  per-channel lock set / clear request.
REQ-013 SHALL have upd_i  input  1  global commit strobe (shadow_p=1 only; ignored otherwise).
REQ-014 SHALL have q_o  output  chnum_p*width_p  active data, same packing as d_i.
REQ-015 SHALL have locked_o, pend_o, chg_o  output  chnum_p each  lock state, staged-value pending, one-cycle change pulse.

Function
REQ-016 A load on channel n SHALL be accepted iff ld_i[n]=1, channel n is OPEN, and main_rst_i=0.
REQ-017 With shadow_p=0, an accepted load SHALL write d_i into the active register at the next edge.
REQ-018 With shadow_p=0, transp_p=1, and dft_mode_scan_mode_i=0, q_o[n] SHALL equal d_i[n] combinationally during an accepted-load cycle; otherwise q_o SHALL equal the active register.
REQ-019 With shadow_p=1, an accepted load SHALL write the staging register and set pend_o[n] at the next edge; q_o SHALL NOT change.
REQ-020 With shadow_p=1, upd_i=1 SHALL copy staging to active for every channel with pend_o=1 and clear those pend_o bits at the next edge; channels with pend_o=0 SHALL be unchanged.
REQ-021 With shadow_p=1, an accepted load on channel n in the same cycle as upd_i SHALL write d_i to both staging and active, and pend_o[n] SHALL be 0 after the edge.
REQ-022 transp_p SHALL have no effect when shadow_p=1.
REQ-023 Each channel SHALL have a two-state FSM, OPEN -> LOCKED on lock_i and LOCKED -> OPEN on unlock_i, taking effect at the next edge; locked_o reflects the state.
REQ-024 When lock_i and unlock_i are asserted together, lock SHALL win.
REQ-025 A load in the same cycle as lock_i on an OPEN channel SHALL be accepted; loads are refused from the following cycle.
REQ-026 While LOCKED, ld_i SHALL be ignored, but upd_i SHALL still commit an already-pending staged value.
REQ-027 chg_o[n] SHALL pulse high for exactly one cycle, the cycle after the active register of channel n took a value different from its previous value; rewriting an equal value SHALL give no pulse.
REQ-028 dft_mode_scan_mode_i=1 SHALL disable transparency only; dft_mode_test_mode_i, dft_mode_scan_shift_i, and dft_mode_mbist_mode_i SHALL be functionally unused.

Reset
REQ-029 main_rst_i=1 SHALL, at the next edge, set every active and staging register to rstval_p, all channels to OPEN, and pend_o and chg_o to 0.
REQ-030 Reset SHALL have priority over ld_i, lock_i, unlock_i, and upd_i in the same cycle, including mid-operation with values pending.
REQ-031 During a reset cycle q_o SHALL show the registered value (no transparency); reset-to-rstval_p SHALL NOT pulse chg_o.

Structure
REQ-032 Package ucdp_hold_bank_pkg SHALL hold the channel-state enum chstate_t (OPEN, LOCKED) and nothing else.
REQ-033 Per-channel logic SHALL live in one sub-module, ucdp_hold_chan, instantiated chnum_p times by a generate loop; upd_i and the dft_mode inputs are broadcast.
REQ-034 The block SHALL contain no latches and no asynchronous logic.

Verification
REQ-035 Test: width_p=8, shadow_p=0, transp_p=1; ld_i=1, d_i=0x5A -> q_o=0x5A in the same cycle, 0x5A held after ld_i drops, and chg_o pulses once.
REQ-036 Test: lock_i=1 with ld_i=1, d_i=0x11 -> 0x11 accepted; next cycle ld_i=1, d_i=0x22 -> q_o stays 0x11 and locked_o=1.
REQ-037 Test: chnum_p=4, shadow_p=1; load ch0=0x01 and ch2=0x03 -> pend_o=0b0101 and q_o unchanged; upd_i -> q_o ch0=0x01, ch2=0x03, pend_o=0.
REQ-038 Test: shadow_p=1; ld_i on ch1 with d_i=0x7F together with upd_i -> ch1 active=0x7F and pend_o[1]=0 after one edge.
REQ-039 Test: with pend_o=0b1111 and ch3 locked, assert main_rst_i together with ld_i and upd_i -> all q_o=rstval_p, pend_o=0, locked_o=0, no chg_o pulse.
REQ-040 Test: lock_i and unlock_i asserted together on an OPEN channel -> locked_o=1; rewriting an equal value -> no chg_o pulse.
